// File: rtl/fwd_select_ctrl_if.sv
// ID-stage hazard/forwarding bus between the pipeline datapath and fwd_select_ctrl.
// The master drives the decoded ID instruction; the slave returns the stall and the EX mux selects.
interface fwd_select_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              stall;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dst, id_reg_write, id_mem_read, flush,
    input  stall, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dst, id_reg_write, id_mem_read, flush,
    output stall, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/fwd_select_ctrl.sv
// MIPS32 forwarding/hazard control: tracks in-flight destinations, computes EX operand-mux
// selects in ID, registers them into EX, and raises a one-cycle load-use stall.
module fwd_select_ctrl #(
  parameter int REG_AW     = 5,
  parameter bit WB1_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  fwd_select_ctrl_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic              mem_read;
  } slot_t;

  localparam slot_t BUBBLE = '{valid: 1'b0, dst: '0, reg_write: 1'b0, mem_read: 1'b0};

  // A producer that is in WB while the consumer is in ID has retired into the WB+1 position
  // once the consumer reaches EX, which is exactly what code 11 bypasses; nothing older matters.
  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d, mem_d, wb_d;

  logic [1:0] fwd_a_sel_q, fwd_b_sel_q;
  logic [1:0] fwd_a_sel_d, fwd_b_sel_d;

  logic hazard_a, hazard_b;
  logic stall;

  function automatic logic slot_writes(slot_t s, logic [REG_AW-1:0] r);
    return s.valid && s.reg_write && (s.dst == r) && (r != '0);
  endfunction

  function automatic logic [1:0] select_for(logic used, logic [REG_AW-1:0] r,
                                            slot_t ex_s, slot_t mem_s, slot_t wb_s);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (r != '0)) begin
      if (slot_writes(ex_s, r))
        sel = 2'b01;
      else if (slot_writes(mem_s, r))
        sel = 2'b10;
      else if (slot_writes(wb_s, r))
        sel = WB1_BYPASS ? 2'b11 : 2'b00;
    end
    return sel;
  endfunction

  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    stall    = 1'b0;
    if (ex_q.valid && ex_q.mem_read) begin
      hazard_a = bus.id_uses_rs && slot_writes(ex_q, bus.id_rs);
      hazard_b = bus.id_uses_rt && slot_writes(ex_q, bus.id_rt);
    end
    // A flushed ID instruction is discarded anyway, so it must never hold the front end.
    stall = bus.id_valid && !bus.flush && (hazard_a || hazard_b);
  end

  always_comb begin
    ex_d        = BUBBLE;
    mem_d       = ex_q;
    wb_d        = mem_q;
    fwd_a_sel_d = 2'b00;
    fwd_b_sel_d = 2'b00;
    if (bus.id_valid && !stall && !bus.flush) begin
      ex_d.valid     = 1'b1;
      ex_d.dst       = bus.id_dst;
      ex_d.reg_write = bus.id_reg_write;
      ex_d.mem_read  = bus.id_mem_read;
      fwd_a_sel_d    = select_for(bus.id_uses_rs, bus.id_rs, ex_q, mem_q, wb_q);
      fwd_b_sel_d    = select_for(bus.id_uses_rt, bus.id_rt, ex_q, mem_q, wb_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      wb_q        <= BUBBLE;
      fwd_a_sel_q <= 2'b00;
      fwd_b_sel_q <= 2'b00;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      fwd_a_sel_q <= fwd_a_sel_d;
      fwd_b_sel_q <= fwd_b_sel_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.fwd_a_sel = fwd_a_sel_q;
  assign bus.fwd_b_sel = fwd_b_sel_q;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Scoreboard bench for fwd_select_ctrl: two DUTs (WB1 bypass on/off) share directed ID vectors;
// expected stall/select values are queued per vector and checked by an independent monitor.
module tb_fwd_select_ctrl;

  logic clk;
  logic rst_n;

  typedef struct {
    logic       stall;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passed = 0;

  fwd_select_ctrl_if #(.REG_AW(5)) bus0 ();
  fwd_select_ctrl_if #(.REG_AW(5)) bus1 ();

  assign bus1.id_valid     = bus0.id_valid;
  assign bus1.id_rs        = bus0.id_rs;
  assign bus1.id_rt        = bus0.id_rt;
  assign bus1.id_uses_rs   = bus0.id_uses_rs;
  assign bus1.id_uses_rt   = bus0.id_uses_rt;
  assign bus1.id_dst       = bus0.id_dst;
  assign bus1.id_reg_write = bus0.id_reg_write;
  assign bus1.id_mem_read  = bus0.id_mem_read;
  assign bus1.flush        = bus0.flush;

  fwd_select_ctrl #(.REG_AW(5), .WB1_BYPASS(1'b1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  fwd_select_ctrl #(.REG_AW(5), .WB1_BYPASS(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act === exp)
      passed++;
    else
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic driveIdle();
    bus0.id_valid     = 1'b0;
    bus0.id_rs        = '0;
    bus0.id_rt        = '0;
    bus0.id_uses_rs   = 1'b0;
    bus0.id_uses_rt   = 1'b0;
    bus0.id_dst       = '0;
    bus0.id_reg_write = 1'b0;
    bus0.id_mem_read  = 1'b0;
    bus0.flush        = 1'b0;
  endtask

  task automatic driveInstr(input logic [4:0] rs, input logic [4:0] rt,
                            input bit urs, input bit urt, input logic [4:0] dst,
                            input bit rw, input bit mr, input bit fl);
    bus0.id_valid     = 1'b1;
    bus0.id_rs        = rs;
    bus0.id_rt        = rt;
    bus0.id_uses_rs   = urs;
    bus0.id_uses_rt   = urt;
    bus0.id_dst       = dst;
    bus0.id_reg_write = rw;
    bus0.id_mem_read  = mr;
    bus0.flush        = fl;
  endtask

  // One ID cycle: stall is expected during this cycle, selects after the next rising edge.
  task automatic applyStimulus(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                               input bit urs, input bit urt, input logic [4:0] dst,
                               input bit rw, input bit mr, input bit fl,
                               input logic es, input logic [1:0] ea, input logic [1:0] eb);
    exp_t e;
    @(negedge clk);
    if (v) driveInstr(rs, rt, urs, urt, dst, rw, mr, fl);
    else   driveIdle();
    e.stall = es;
    e.a     = ea;
    e.b     = eb;
    expQ.push_back(e);
  endtask

  task automatic nop();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_queue_empty", (expQ.size() == 0) ? 2'b01 : 2'b00, 2'b01);
    @(posedge clk);
    #2;
    driveIdle();
  endtask

  // Monitor: consumes one expectation per ID cycle and compares both DUTs.
  initial begin : monitor
    exp_t e;
    logic [1:0] eb1a, eb1b;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("stall_wb1on",  {1'b0, bus0.stall}, {1'b0, e.stall});
        checkOutput("stall_wb1off", {1'b0, bus1.stall}, {1'b0, e.stall});
        eb1a = (e.a == 2'b11) ? 2'b00 : e.a;
        eb1b = (e.b == 2'b11) ? 2'b00 : e.b;
        @(posedge clk);
        #1;
        checkOutput("sel_a_wb1on",  bus0.fwd_a_sel, e.a);
        checkOutput("sel_b_wb1on",  bus0.fwd_b_sel, e.b);
        checkOutput("sel_a_wb1off", bus1.fwd_a_sel, eb1a);
        checkOutput("sel_b_wb1off", bus1.fwd_b_sel, eb1b);
      end
    end
  end

  task automatic testBackToBack();
    nops(3);
    // add $3,$1,$2 ; add $4,$3,$1
    applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1, 3, 1, 1, 1, 4, 1, 0, 0, 1'b0, 2'b01, 2'b00);
    nops(3);
  endtask

  initial begin : stimulus
    rst_n = 1'b0;
    driveIdle();
    #7;
    checkOutput("reset_a",     bus0.fwd_a_sel, 2'b00);
    checkOutput("reset_b",     bus0.fwd_b_sel, 2'b00);
    checkOutput("reset_stall", {1'b0, bus0.stall}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    testBackToBack();

    // Writer of $7 then consumer at distance 2, 3, 4
    applyStimulus(1, 1, 2, 1, 1, 7, 1, 0, 0, 1'b0, 2'b00, 2'b00);
    nop();
    applyStimulus(1, 7, 2, 1, 1, 8, 1, 0, 0, 1'b0, 2'b10, 2'b00);
    nops(3);
    applyStimulus(1, 1, 2, 1, 1, 7, 1, 0, 0, 1'b0, 2'b00, 2'b00);
    nops(2);
    applyStimulus(1, 2, 7, 1, 1, 8, 1, 0, 0, 1'b0, 2'b00, 2'b11);
    nops(3);
    applyStimulus(1, 1, 2, 1, 1, 7, 1, 0, 0, 1'b0, 2'b00, 2'b00);
    nops(3);
    applyStimulus(1, 7, 7, 1, 1, 8, 1, 0, 0, 1'b0, 2'b00, 2'b00);
    nops(3);

    // lw $5,0($1) ; add $6,$5,$5 -> one stall cycle, then MEM forward on both
    applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1, 5, 5, 1, 1, 6, 1, 0, 0, 1'b1, 2'b00, 2'b00);
    applyStimulus(1, 5, 5, 1, 1, 6, 1, 0, 0, 1'b0, 2'b10, 2'b10);
    nops(3);

    // Writes to $0 never forward; youngest of two $9 writers wins
    applyStimulus(1, 1, 2, 1, 1, 0, 1, 0, 0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1, 0, 0, 1, 1, 10, 1, 0, 0, 1'b0, 2'b00, 2'b00);
    nops(3);
    applyStimulus(1, 1, 2, 1, 1, 9, 1, 0, 0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1, 1, 2, 1, 1, 9, 1, 0, 0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1, 9, 9, 1, 1, 11, 1, 0, 0, 1'b0, 2'b01, 2'b01);
    nops(3);
    // Unused operand never forwards even when its register is in flight
    applyStimulus(1, 1, 2, 1, 1, 12, 1, 0, 0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1, 12, 12, 0, 1, 13, 1, 0, 0, 1'b0, 2'b00, 2'b01);
    nops(3);

    // Flushed writer of $8 is a bubble; flush overrides load-use
    applyStimulus(1, 1, 2, 1, 1, 8, 1, 0, 1, 1'b0, 2'b00, 2'b00);
    applyStimulus(1, 8, 2, 1, 1, 10, 1, 0, 0, 1'b0, 2'b00, 2'b00);
    nops(3);
    applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1, 5, 2, 1, 1, 6, 1, 0, 1, 1'b0, 2'b00, 2'b00);
    applyStimulus(1, 5, 2, 1, 1, 6, 1, 0, 0, 1'b0, 2'b10, 2'b00);
    nops(3);
    drain();

    // Asynchronous reset mid-stream while a stall is pending and a select is non-zero
    @(negedge clk);
    driveInstr(1, 2, 1, 1, 3, 1, 0, 0);
    @(negedge clk);
    driveInstr(3, 0, 1, 0, 5, 1, 1, 0);
    @(negedge clk);
    driveInstr(5, 1, 1, 1, 6, 1, 0, 0);
    #2;
    checkOutput("prereset_stall", {1'b0, bus0.stall}, 2'b01);
    checkOutput("prereset_a",     bus0.fwd_a_sel, 2'b01);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_a_wb1on",      bus0.fwd_a_sel, 2'b00);
    checkOutput("midreset_b_wb1on",      bus0.fwd_b_sel, 2'b00);
    checkOutput("midreset_stall_wb1on",  {1'b0, bus0.stall}, 2'b00);
    checkOutput("midreset_a_wb1off",     bus1.fwd_a_sel, 2'b00);
    checkOutput("midreset_stall_wb1off", {1'b0, bus1.stall}, 2'b00);
    driveIdle();
    @(negedge clk);
    rst_n = 1'b1;

    testBackToBack();
    drain();

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
